// File: rtl/tri_index_down_seq_pkg.sv
// Shared types and helpers for the descending triangular index sequencer.
package tri_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // max(1, clog2(n)): a one-entry matrix still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tri_index_down_seq_if.sv
// Valid/ready stream carrying one (row, col) pair of the triangle per beat.
interface tri_index_down_seq_if #(
  parameter int IDX_W = 2
);
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic             diag;
  logic             last;

  modport master (
    output out_valid, row, col, diag, last,
    input  out_ready
  );

  modport slave (
    input  out_valid, row, col, diag, last,
    output out_ready
  );
endinterface

// File: rtl/tri_index_down_seq_counter_mod_down.sv
// Modulo-MOD down-counter: loads MOD-1 on reset_count, wraps from 0 to MOD-1.
module counter_mod_down
  import tri_seq_pkg::*;
#(
  parameter  int MOD = 4,
  localparam int W   = idx_width(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reset_count,
  input  logic         down,
  output logic         min,
  output logic [W-1:0] out
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  logic [W-1:0] out_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_reg <= TOP;
    end else if (reset_count) begin
      out_reg <= TOP;
    end else if (down) begin
      out_reg <= (out_reg == '0) ? TOP : out_reg - 1'b1;
    end
  end

  assign out = out_reg;
  assign min = (out_reg == '0);

endmodule

// File: rtl/tri_index_down_seq.sv
// Walks the upper triangle of an N x N matrix from (N-1,N-1) down to (0,0),
// one (row, col) pair per accepted valid/ready beat.
module tri_index_down_seq
  import tri_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  output logic                 busy,
  output logic                 done,
  tri_index_down_seq_if.master bus
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col_reg;
  logic [IDX_W-1:0] col_next;
  logic             row_min;
  logic             valid;
  logic             handshake;
  logic             at_diag;
  logic             at_last;
  logic             reload;
  logic             row_down;

  assign valid     = (state_reg == RUN);
  assign handshake = valid && bus.out_ready;
  assign at_diag   = (col_reg == row);
  assign at_last   = at_diag && row_min;

  // Both indices return to N-1 whenever the block is (re)entering IDLE or
  // starting, so the next traversal always opens at the bottom-right corner.
  assign reload   = clear || (state_reg == IDLE && start) || (state_reg == DONE);
  assign row_down = !clear && handshake && at_diag && !row_min;

  counter_mod_down #(
    .MOD (N)
  ) u_row (
    .clk         (clk),
    .rst         (rst),
    .reset_count (reload),
    .down        (row_down),
    .min         (row_min),
    .out         (row)
  );

  // Column counts down to a floor equal to the current row, then reloads.
  always_comb begin
    col_next = col_reg;
    if (reload) begin
      col_next = MAX_IDX;
    end else if (handshake) begin
      if (!at_diag) begin
        col_next = col_reg - 1'b1;
      end else if (!row_min) begin
        col_next = MAX_IDX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg <= MAX_IDX;
    end else begin
      col_reg <= col_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (handshake && at_last) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_reg)
      RUN: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign bus.row  = row;
  assign bus.col  = col_reg;
  assign bus.diag = at_diag;
  assign bus.last = at_last;

endmodule

// File: tb/tb_tri_index_down_seq.sv
// Scoreboard bench: three sequencers (N=4, N=1, N=5) driven by one stimulus
// process; a negedge monitor compares every beat and status probe.
module tb_tri_index_down_seq;

  typedef struct {
    int i;
    int j;
    bit dg;
    bit ls;
  } beat_t;

  // kind 0: status probe, 1: forced failure, 2: scoreboard empty, 3: busy length
  typedef struct {
    int    d;
    int    kind;
    bit    v;
    bit    b;
    bit    dn;
    bit    rc;
    int    r;
    int    c;
    string name;
  } req_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [3];
  logic       clr     [3];
  logic       rdy     [3];
  logic       v       [3];
  logic       bz      [3];
  logic       dn      [3];
  logic       dg      [3];
  logic       ls      [3];
  logic [2:0] r       [3];
  logic [2:0] c       [3];

  beat_t bq [3][$];
  req_t  rq [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tri_index_down_seq_if #(.IDX_W(2)) if0 ();
  tri_index_down_seq_if #(.IDX_W(1)) if1 ();
  tri_index_down_seq_if #(.IDX_W(3)) if2 ();

  tri_index_down_seq #(.N(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .clear(clr[0]),
    .busy(bz[0]), .done(dn[0]), .bus(if0)
  );
  tri_index_down_seq #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .clear(clr[1]),
    .busy(bz[1]), .done(dn[1]), .bus(if1)
  );
  tri_index_down_seq #(.N(5)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .clear(clr[2]),
    .busy(bz[2]), .done(dn[2]), .bus(if2)
  );

  assign if0.out_ready = rdy[0];
  assign if1.out_ready = rdy[1];
  assign if2.out_ready = rdy[2];

  assign v[0]  = if0.out_valid;
  assign v[1]  = if1.out_valid;
  assign v[2]  = if2.out_valid;
  assign dg[0] = if0.diag;
  assign dg[1] = if1.diag;
  assign dg[2] = if2.diag;
  assign ls[0] = if0.last;
  assign ls[1] = if1.last;
  assign ls[2] = if2.last;
  assign r[0]  = {1'b0, if0.row};
  assign c[0]  = {1'b0, if0.col};
  assign r[1]  = {2'b00, if1.row};
  assign c[1]  = {2'b00, if1.col};
  assign r[2]  = if2.row;
  assign c[2]  = if2.col;

  // ---------------- monitor ----------------
  bit    exp_done  [3];
  bit    prev_hold [3];
  int    prev_r    [3];
  int    prev_c    [3];
  int    busy_len  [3];
  int    last_len  [3];
  beat_t mb;
  req_t  mr;

  task automatic check(input string nm, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      check("done_pulse", d, int'(dn[d]), int'(exp_done[d]));
      exp_done[d] = 1'b0;
      check("busy_eq_valid", d, int'(bz[d]), int'(v[d]));
      if (v[d] && prev_hold[d]) begin
        check("hold_row", d, int'(r[d]), prev_r[d]);
        check("hold_col", d, int'(c[d]), prev_c[d]);
      end
      if (v[d] && rdy[d]) begin
        if (bq[d].size() == 0) begin
          check("extra_beat", d, 1, 0);
        end else begin
          mb = bq[d].pop_front();
          $display("beat dut%0d row=%0d col=%0d diag=%0d last=%0d (want %0d,%0d)",
                   d, r[d], c[d], dg[d], ls[d], mb.i, mb.j);
          check("beat_row", d, int'(r[d]), mb.i);
          check("beat_col", d, int'(c[d]), mb.j);
          check("beat_diag", d, int'(dg[d]), int'(mb.dg));
          check("beat_last", d, int'(ls[d]), int'(mb.ls));
          if (mb.ls && !clr[d] && rst) exp_done[d] = 1'b1;
        end
      end
      prev_hold[d] = v[d] && !rdy[d] && !clr[d] && rst;
      prev_r[d]    = int'(r[d]);
      prev_c[d]    = int'(c[d]);
      if (bz[d]) begin
        busy_len[d]++;
      end else begin
        if (busy_len[d] > 0) last_len[d] = busy_len[d];
        busy_len[d] = 0;
      end
    end
    while (rq.size() > 0) begin
      mr = rq.pop_front();
      case (mr.kind)
        0: begin
          check({mr.name, "_valid"}, mr.d, int'(v[mr.d]), int'(mr.v));
          check({mr.name, "_busy"}, mr.d, int'(bz[mr.d]), int'(mr.b));
          check({mr.name, "_done"}, mr.d, int'(dn[mr.d]), int'(mr.dn));
          if (mr.rc) begin
            check({mr.name, "_row"}, mr.d, int'(r[mr.d]), mr.r);
            check({mr.name, "_col"}, mr.d, int'(c[mr.d]), mr.c);
          end
        end
        1:       check(mr.name, mr.d, 1, 0);
        2:       check(mr.name, mr.d, bq[mr.d].size(), 0);
        default: check(mr.name, mr.d, last_len[mr.d], mr.r);
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_status(input int d, input bit vv, input bit bb, input bit dd,
                             input bit rc, input int rr, input int cc, input string nm);
    req_t q;
    q.d = d; q.kind = 0; q.v = vv; q.b = bb; q.dn = dd;
    q.rc = rc; q.r = rr; q.c = cc; q.name = nm;
    rq.push_back(q);
  endtask

  task automatic push_kind(input int d, input int kind, input int val, input string nm);
    req_t q;
    q.d = d; q.kind = kind; q.v = 0; q.b = 0; q.dn = 0;
    q.rc = 0; q.r = val; q.c = 0; q.name = nm;
    rq.push_back(q);
  endtask

  // Reference order: rows from N-1 down to 0, each row's columns from N-1 down to the row.
  function automatic void gen(input int d, input int n);
    int k   = 0;
    int tot = n * (n + 1) / 2;
    for (int i = n - 1; i >= 0; i--) begin
      for (int j = n - 1; j >= i; j--) begin
        beat_t e;
        k++;
        e.i  = i;
        e.j  = j;
        e.dg = (i == j);
        e.ls = (k == tot);
        bq[d].push_back(e);
      end
    end
  endfunction

  // mode 0: ready held high, 1: ready pattern 1,0,0, 2: random ready
  task automatic traverse(input int d, input int n, input int mode,
                          input int clear_at, input int rst_at, input int restart_at);
    int tot = n * (n + 1) / 2;
    int hsn = 0;
    int cyc = 0;
    bit rd;
    gen(d, n);
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    push_status(d, 1, 1, 0, 1, n - 1, n - 1, "first_pair");
    while (hsn < tot && cyc < 300) begin
      rd = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      if (hsn + 1 == clear_at || hsn + 1 == rst_at) rd = 1'b1;
      rdy[d] = rd;
      if (hsn + 1 == restart_at) start_s[d] = 1'b1;
      if (hsn + 1 == clear_at) clr[d] = 1'b1;
      if (hsn + 1 == rst_at) begin
        #2;
        rst = 1'b0;
        bq[d].delete();
        push_status(d, 0, 0, 0, 1, n - 1, n - 1, "async_reset");
        @(posedge clk); #1;
        rst    = 1'b1;
        rdy[d] = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start_s[d] = 1'b0;
      if (clr[d]) begin
        clr[d] = 1'b0;
        rdy[d] = 1'b0;
        bq[d].delete();
        push_status(d, 0, 0, 0, 1, n - 1, n - 1, "after_clear");
        return;
      end
      if (rd) hsn++;
      cyc++;
    end
    rdy[d] = 1'b0;
    if (hsn < tot) begin
      push_kind(d, 1, 0, "traversal_timeout");
      return;
    end
    push_status(d, 0, 0, 1, 0, 0, 0, "done_cycle");
    @(posedge clk); #1;
    push_status(d, 0, 0, 0, 1, n - 1, n - 1, "back_idle");
    if (mode == 0) push_kind(d, 3, tot, "busy_cycles");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      clr[d]     = 1'b0;
      rdy[d]     = 1'b0;
    end
    push_status(0, 0, 0, 0, 1, 3, 3, "reset");
    push_status(1, 0, 0, 0, 1, 0, 0, "reset");
    push_status(2, 0, 0, 0, 1, 4, 4, "reset");
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    traverse(0, 4, 0, 0, 0, 0);          // full traversal
    traverse(0, 4, 1, 0, 0, 0);          // backpressure
    traverse(0, 4, 0, 0, 0, 5);          // start while busy
    traverse(0, 4, 0, 0, 0, 0);          // start right after done
    traverse(0, 4, 0, 6, 0, 0);          // clear at (1,1)
    traverse(0, 4, 0, 0, 0, 0);
    traverse(0, 4, 0, 0, 3, 0);          // async reset during beat 3
    traverse(0, 4, 0, 0, 0, 0);

    // start and clear together in IDLE: clear wins
    start_s[0] = 1'b1;
    clr[0]     = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    clr[0]     = 1'b0;
    push_status(0, 0, 0, 0, 1, 3, 3, "start_clear_idle");
    @(posedge clk); #1;
    push_status(0, 0, 0, 0, 1, 3, 3, "start_clear_idle2");

    traverse(1, 1, 0, 0, 0, 0);          // N=1
    traverse(2, 5, 0, 0, 0, 0);          // N=5
    for (int k = 0; k < 3; k++) begin
      traverse(0, 4, 2, 0, 0, 0);
      traverse(2, 5, 2, 0, 0, 0);
      traverse(1, 1, 2, 0, 0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) push_kind(d, 2, 0, "scoreboard_empty");
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tri_index_down_seq.md
Name: tri_index_down_seq

Overview:
- Descending index sequencer for the back-substitution stage of the LCMV solver.
- It walks the upper triangle of an N x N matrix from the bottom-right corner to the top-left. It emits one (row, col) pair per accepted beat over a valid/ready handshake.
- It is the counting-down counterpart to the existing up-counting counter_mod chain used for forward traversal. It feeds the read address of the triangular-matrix memory.

Parameters:
- N, default 4: matrix dimension. Legal range N >= 1.
- IDX_W, default max(1,$clog2(N)): width of the row and col outputs. Derived; do not override.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset (rst=0 resets).
- start, input, 1: pulse that begins a traversal; honoured only in IDLE.
- clear, input, 1: synchronous abort; returns the block to IDLE.
- out_valid, output, 1: a (row, col) pair is presented.
- out_ready, input, 1: the consumer accepts the current pair.
- row, output, IDX_W: current row index i.
- col, output, IDX_W: current column index j.
- diag, output, 1: j == i, i.e. the last element of the row.
- last, output, 1: i == 0 and j == 0, i.e. the final beat of the traversal.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse after the final handshake.

Behaviour:
- Sequence: for i = N-1 down to 0, for j = N-1 down to i, emit (i, j). That is N(N+1)/2 beats in total.
- Reset (rst=0, asynchronous): state=IDLE; row=N-1; col=N-1; out_valid=0; busy=0; done=0; diag and last follow the reset row/col values but are don't-care while out_valid=0.
- States:
  - IDLE: out_valid=0. On start=1, load row=N-1, col=N-1 and go to RUN. out_valid rises the cycle after start (latency 1).
  - RUN: out_valid=1, busy=1. A beat is consumed only on the cycle where out_valid and out_ready are both high.
    - With out_ready=0, row, col, diag and last hold stable.
    - On a handshake with col > row: col decrements by 1.
    - On a handshake with col == row and row > 0: row decrements by 1 and col reloads to N-1 (wrap-around).
    - On a handshake with last=1: go to DONE.
  - DONE: out_valid=0 and done=1 for exactly one cycle, then go to IDLE with row and col reloaded to N-1.
- start while in RUN or DONE is ignored; there is no queueing.
- clear=1 in any state: the next state is IDLE and out_valid drops next cycle.
  - clear has priority over start and over a simultaneous handshake; no done pulse is produced.
  - start and clear asserted in the same IDLE cycle: clear wins and the block stays IDLE.
- N=1: a single beat (0,0) with diag=1 and last=1, then done.
- Arithmetic: decrements are performed at IDX_W bits. row never goes below 0, because the transition to DONE happens at row==0 and col==0.
- diag and last are combinational from row and col. They are qualified by out_valid.
- Asserting rst mid-traversal aborts immediately to the reset values with no done pulse.

Decomposition:
- Package tri_seq_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the function idx_width(n), returning max(1,$clog2(n)).
- Sub-module counter_mod_down (parameter MOD), the downward twin of counter_mod:
  - ports: reset_count (loads MOD-1), down, min (out==0), out;
  - it wraps from 0 to MOD-1 when down is asserted at min.
- Column counter: a loadable down-counter whose floor is the current row. It is implemented locally, since its floor varies per row.

Test Plan:
- Full traversal, N=4, out_ready held at 1, start pulsed once:
  - Required: exactly 10 beats, in order (3,3) (2,3) (2,2) (1,3) (1,2) (1,1) (0,3) (0,2) (0,1) (0,0).
  - diag=1 on (3,3), (2,2), (1,1) and (0,0); last=1 only on (0,0).
  - done pulses once, one cycle after the (0,0) handshake; busy is high for exactly 10 cycles.
- Backpressure, N=4, out_ready toggling 1,0,0,1,...:
  - Required: the pair holds stable while out_ready=0; the sequence is identical to the first scenario; no beat is duplicated or skipped.
- Start while busy, N=4:
  - Required: start re-pulsed at beat 5 is ignored and the traversal completes normally.
  - A start one cycle after done yields a fresh sequence beginning at (3,3).
- Abort, N=4:
  - clear at beat 6 (pair (1,1)) with out_ready=1: out_valid=0 next cycle, no done pulse, row=col=3.
  - A following start restarts the sequence at (3,3).
- Asynchronous reset mid-run:
  - rst driven low between clock edges during beat 3: outputs go to reset values immediately, without waiting for a clock edge.
  - After reset release plus a start, the first pair is (3,3).
- N=1 instance:
  - One beat (0,0) with diag=1 and last=1, followed by the done pulse.
  - N=5 instance: 15 beats ending at (0,0).
